// File: rtl/sar_search.sv
// sar_search: binary-search initiator that locates a comparator's b operand
// from its grth/lsth/eq flags, reporting the value found and the probes used.
module sar_search #(
   parameter int W = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     grth,
   input  logic                     lsth,
   input  logic                     eq,
   output logic [W-1:0]             probe,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic [W-1:0]             found,
   output logic [$clog2(W+2)-1:0]   steps
);
   localparam int SW = $clog2(W+2);
   typedef enum logic [1:0] {IDLE, PROBE, DONE, ERR} state_t;
   state_t state_q, state_d;
   logic [W:0] lo_q, lo_d, hi_q, hi_d, pe;
   logic [W-1:0] probe_q, probe_d, found_q, found_d;
   logic [SW-1:0] steps_q, steps_d;
   always_comb begin
      state_d = state_q;
      lo_d = lo_q;
      hi_d = hi_q;
      probe_d = probe_q;
      found_d = found_q;
      steps_d = steps_q;
      pe = {1'b0, probe_q};
      case (state_q)
         IDLE: if (start) begin
            lo_d = '0;
            hi_d = {1'b0, {W{1'b1}}};
            probe_d = {1'b0, {(W-1){1'b1}}};
            found_d = '0;
            steps_d = '0;
            state_d = PROBE;
         end
         PROBE: begin
            steps_d = steps_q + 1'b1;
            // a flag that would push lo past hi means the comparator lied
            if (eq && !grth && !lsth) begin
               found_d = probe_q;
               state_d = DONE;
            end
            else if (grth && !lsth && !eq && pe != lo_q) hi_d = pe - 1'b1;
            else if (lsth && !grth && !eq && pe != hi_q) lo_d = pe + 1'b1;
            else state_d = ERR;
            if (state_d == PROBE) probe_d = W'((lo_d + hi_d) >> 1);
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         lo_q <= '0;
         hi_q <= '0;
         probe_q <= '0;
         found_q <= '0;
         steps_q <= '0;
      end else begin
         state_q <= state_d;
         lo_q <= lo_d;
         hi_q <= hi_d;
         probe_q <= probe_d;
         found_q <= found_d;
         steps_q <= steps_d;
      end
   end
   assign probe = probe_q;
   assign found = found_q;
   assign steps = steps_q;
   assign busy = state_q == PROBE;
   assign done = state_q == DONE;
   assign err = state_q == ERR;
endmodule

// File: tb/tb_sar_search.sv
// tb_sar_search: randomized and directed searches against a behavioural binary-search
// model; expected probes and results are queued and checked by an independent monitor.
module tb_sar_search;
   localparam int W = 3;
   typedef struct {
      bit e;
      int f;
      int s;
   } res_t;
   logic clk = 0, rst = 1, start = 0, grth, lsth, eq;
   logic [W-1:0] probe, found;
   logic busy, done, err;
   logic [$clog2(W+2)-1:0] steps;
   int mode = 0, target = 0, checks = 0, errors = 0;
   bit mon_en = 0;
   int exp_probe[$];
   res_t exp_res[$];
   res_t mr;

   sar_search #(.W(W)) dut (
      .clk(clk), .rst(rst), .start(start), .grth(grth), .lsth(lsth), .eq(eq),
      .probe(probe), .busy(busy), .done(done), .err(err), .found(found), .steps(steps)
   );

   always #5 clk = ~clk;

   // mode 0 ideal comparator; 1 silent; 2 stuck greater; 3 eq+lsth together
   always_comb begin
      grth = (mode == 0) ? (int'(probe) > target) : (mode == 2);
      lsth = (mode == 0) ? (int'(probe) < target) : (mode == 3);
      eq   = (mode == 0) ? (int'(probe) == target) : (mode == 3);
   end

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int model(int tgt, int md);
      int lo = 0, hi = (1 << W) - 1, n = 0, p;
      bit g, l, e;
      res_t r;
      while (1) begin
         p = (lo + hi) / 2;
         exp_probe.push_back(p);
         n++;
         g = (md == 0) ? (p > tgt) : (md == 2);
         l = (md == 0) ? (p < tgt) : (md == 3);
         e = (md == 0) ? (p == tgt) : (md == 3);
         if (e && !g && !l) begin
            r = '{1'b0, p, n};
            break;
         end
         if (g && !l && !e && p != lo) hi = p - 1;
         else if (l && !g && !e && p != hi) lo = p + 1;
         else begin
            r = '{1'b1, 0, n};
            break;
         end
      end
      exp_res.push_back(r);
      return n;
   endfunction

   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if (busy) begin
            if (exp_probe.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL probe: unexpected probe %0d, none expected", probe);
            end else chk("probe", int'(probe), exp_probe.pop_front());
         end
         if (done || err) begin
            if (exp_res.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL result: unexpected done=%0d err=%0d", done, err);
            end else begin
               mr = exp_res.pop_front();
               chk("err", int'(err), int'(mr.e));
               chk("done", int'(done), int'(!mr.e));
               chk("found", int'(found), mr.f);
               chk("steps", int'(steps), mr.s);
            end
         end
      end
   end

   task automatic run(int tgt, int md, int hold);
      int n, cnt;
      @(negedge clk);
      target = tgt;
      mode = md;
      n = model(tgt, md);
      start = 1;
      cnt = 0;
      while (1) begin
         @(negedge clk);
         cnt++;
         if (cnt > hold) start = 0;
         if (done || err) break;
         if (cnt > 20) begin
            $display("FAIL timeout: no done/err after %0d cycles", cnt);
            break;
         end
      end
      start = 0;
      chk("latency", cnt, n + 1);
   endtask

   task automatic chk_zero(string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_err"}, int'(err), 0);
      chk({tag, "_probe"}, int'(probe), 0);
      chk({tag, "_found"}, int'(found), 0);
      chk({tag, "_steps"}, int'(steps), 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk_zero("reset");
      rst = 0;
      mon_en = 1;
      run(5, 0, 0);
      run(7, 0, 0);
      run(0, 0, 0);
      for (int t = 0; t < 8; t++) run(t, 0, 0);
      run(4, 1, 0);
      run(2, 2, 0);
      run(6, 3, 0);
      run(7, 0, 3);
      @(negedge clk);
      target = 7;
      mode = 0;
      void'(model(7, 0));
      start = 1;
      @(negedge clk);
      start = 0;
      @(negedge clk);
      rst = 1;
      start = 1;
      @(negedge clk);
      chk_zero("abort");
      rst = 0;
      start = 0;
      exp_probe.delete();
      exp_res.delete();
      run(7, 0, 0);
      for (int i = 0; i < 40; i++)
         run(int'($urandom_range(7)), ($urandom_range(9) < 7) ? 0 : int'($urandom_range(3, 1)), 0);
      @(negedge clk);
      chk("pending_results", exp_res.size(), 0);
      chk("pending_probes", exp_probe.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sar_search.md
# sar_search

Successive-approximation search engine: the initiator that drives a magnitude comparator and locates an unknown W-bit target using only the comparator's greater/less/equal flags. On `start` it presents binary-search probe values on `probe` (the comparator's `a` operand; the target is the comparator's `b` operand) and reads back the flags. It reports the found value and the probe count, or an error if the flags are inconsistent. The block sits beside the ALU comparator and provides search, threshold-finding and comparator self-check.

## Interface
- `W`, default 3: operand width; the search range is 0 .. 2^W-1.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  begin a search; sampled only in IDLE.
- `grth`  in  1  comparator flag, `probe` > target.
- `lsth`  in  1  comparator flag, `probe` < target.
- `eq`  in  1  comparator flag, `probe` == target.
- `probe`  out  W  registered probe value driven to the comparator.
- `busy`  out  1  high in PROBE.
- `done`  out  1  one-cycle pulse on successful completion.
- `err`  out  1  one-cycle pulse on inconsistent flags.
- `found`  out  W  located target; held until the next `start`.
- `steps`  out  clog2(W+2)  probes used in the last search; held until the next `start`.

## Operation
- States: IDLE, PROBE, DONE, ERR.
- Reset values: state IDLE; `probe`, `found`, `steps` = 0; `busy`, `done`, `err` = 0.
- IDLE:
  - With `start`=1: `lo`←0, `hi`←2^W-1, `probe`←(2^W-1)>>1, clear `found` and `steps`, go to PROBE.
  - With `start`=0: stay in IDLE.
- PROBE: each cycle, sample the flags against the current `probe` and increment `steps`.
  - Exactly `eq`: `found`←`probe`, go to DONE.
  - Exactly `grth`: if `probe`==`lo`, go to ERR; else `hi`←`probe`-1.
  - Exactly `lsth`: if `probe`==`hi`, go to ERR; else `lo`←`probe`+1.
  - No flag set, or more than one set: go to ERR.
  - Next probe = (new `lo` + new `hi`) >> 1.
- Arithmetic:
  - `lo`, `hi` and their sum are computed W+1 bits wide, so there is no overflow.
  - The ERR guards guarantee `lo`<=`hi` at all times; no underflow of `hi` at 0 and no overflow of `lo` at 2^W-1.
- DONE: `done`=1 for one cycle, then IDLE.
- ERR: `err`=1 for one cycle, then IDLE.
  - `found` keeps its cleared value of 0.
  - `steps` includes the failing probe.
- `probe` holds its last value outside PROBE.
- `start` is ignored in PROBE, DONE and ERR; it is not queued.
- `rst` has priority over everything in any state: it aborts the search and restores reset values on the next edge.
- Maximum probes: W+1 (4 for W=3).

## Timing
- `start` sampled at edge 0 → first probe valid in cycle 1.
- The comparator path is combinational. Flags must be valid in the same cycle `probe` is presented; they are sampled on that cycle's closing edge.
- One probe per cycle; no wait states.
- Search using N probes: `done` (or `err`) is high in cycle N+1; IDLE from cycle N+2.
- A new `start` is accepted in the first IDLE cycle, cycle N+2.
- `busy` is high exactly for cycles 1..N.
- `found` and `steps` update on the same edge that raises `done`.

## Test plan
- W=3, target 5, ideal comparator model, `start` pulse.
  - Required: probes 3, 5.
  - `done` in cycle 3; `found`=5, `steps`=2.
- Target 7.
  - Required: probes 3, 5, 6, 7.
  - `done` in cycle 5; `found`=7, `steps`=4.
- Target 0.
  - Required: probes 3, 1, 0; `found`=0, `steps`=3.
- Exhaustive sweep of targets 0..7, back-to-back `start` asserted in each first IDLE cycle.
  - Required: `found`==target every time; `steps`<=4; no `err`.
- Faulty comparator.
  - All flags 0 on the first probe → `err` in cycle 2, `steps`=1, `found`=0.
  - `grth`=1 while `probe`==`lo`=0 → `err`.
  - `eq`=1 and `lsth`=1 together → `err`.
- `rst` asserted in cycle 2 of a target-7 search.
  - Required: next cycle IDLE with all outputs 0.
  - A `start` during the search is ignored.
  - A fresh search then completes normally.
